// File: rtl/clk_div_prog.sv
// Programmable clock divider with a one-deep divisor request buffer.
// o_clk is high for ceil(D/2) and low for floor(D/2) of every D enabled cycles.
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  output logic             o_div_err,
  output logic             o_clk,
  output logic             o_tick,
  output logic [WIDTH-1:0] o_div_active
);

  localparam logic [WIDTH-1:0] RST_DIV_W = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X     = (WIDTH+1)'(1);

  logic [WIDTH-1:0] ctr_q, ctr_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   half;
  logic [WIDTH:0]   ctr_inc;
  logic             wrap;
  logic             accept;

  always_comb begin
    half       = ({1'b0, div_q} + ONE_X) >> 1;
    ctr_inc    = {1'b0, ctr_q} + ONE_X;
    wrap       = i_en && (ctr_q == (div_q - ONE_W));
    accept     = i_div_valid && !pend_vld_q;

    ctr_d      = ctr_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    err_d      = 1'b0;

    if (i_en) begin
      if (wrap) begin
        ctr_d  = '0;
        clk_d  = 1'b1;
        tick_d = 1'b1;
        if (pend_vld_q) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        ctr_d = ctr_inc[WIDTH-1:0];
        clk_d = (ctr_inc < half);
      end
    end else if (pend_vld_q) begin
      // While frozen, park the counter at P-1 so resuming starts a fresh period
      div_d      = pend_q;
      ctr_d      = pend_q - ONE_W;
      pend_vld_d = 1'b0;
    end

    // Requests are only accepted while nothing is pending, so this never
    // collides with the pending-clear above
    if (accept) begin
      if (i_div != '0) begin
        pend_d     = i_div;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctr_q      <= RST_DIV_W - ONE_W;
      div_q      <= RST_DIV_W;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign o_div_ready  = !pend_vld_q;
  assign o_div_err    = err_q;
  assign o_clk        = clk_q;
  assign o_tick       = tick_q;
  assign o_div_active = div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: each vector is one clock with hand-derived
// expected outputs, checked 1ns after the rising edge.
module tb_clk_div_prog;

  localparam int WIDTH = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_en;
  logic [WIDTH-1:0] i_div;
  logic             i_div_valid;
  logic             o_div_ready;
  logic             o_div_err;
  logic             o_clk;
  logic             o_tick;
  logic [WIDTH-1:0] o_div_active;

  int checks   = 0;
  int failures = 0;

  clk_div_prog #(.WIDTH(WIDTH), .RESET_DIV(6)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_div        (i_div),
    .i_div_valid  (i_div_valid),
    .o_div_ready  (o_div_ready),
    .o_div_err    (o_div_err),
    .o_clk        (o_clk),
    .o_tick       (o_tick),
    .o_div_active (o_div_active)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic valid, input int div);
    i_rst       = rst;
    i_en        = en;
    i_div_valid = valid;
    i_div       = WIDTH'(div);
    @(posedge i_clk);
    #1;
  endtask

  task automatic runVector(input string tag, input logic rst, input logic en, input logic valid,
                           input int div, input int e_clk, input int e_tick, input int e_err,
                           input int e_rdy, input int e_act);
    applyStimulus(rst, en, valid, div);
    checkOutput({tag, ".clk"},    {31'b0, o_clk},       e_clk);
    checkOutput({tag, ".tick"},   {31'b0, o_tick},      e_tick);
    checkOutput({tag, ".err"},    {31'b0, o_div_err},   e_err);
    checkOutput({tag, ".ready"},  {31'b0, o_div_ready}, e_rdy);
    checkOutput({tag, ".active"}, {24'b0, o_div_active}, e_act);
  endtask

  int a_clk [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_div_valid = 1'b0; i_div = '0;

    // Reset values, then a free-running D=6 output
    runVector("A.rst0", 1, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("A.rst1", 1, 1, 1, 3, 0, 0, 0, 1, 6);
    for (int i = 0; i < 12; i++)
      runVector($sformatf("A.c%0d", i + 1), 0, 1, 0, 0,
                a_clk[i], (i == 0 || i == 6) ? 1 : 0, 0, 1, 6);

    // Request 5 mid-period; requests while not ready are ignored
    runVector("B.rst", 1, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("B.c1",  0, 1, 0, 0, 1, 1, 0, 1, 6);
    runVector("B.c2",  0, 1, 1, 5, 1, 0, 0, 0, 6);
    runVector("B.c3",  0, 1, 0, 0, 1, 0, 0, 0, 6);
    runVector("B.c4",  0, 1, 1, 0, 0, 0, 0, 0, 6);
    runVector("B.c5",  0, 1, 1, 3, 0, 0, 0, 0, 6);
    runVector("B.c6",  0, 1, 0, 0, 0, 0, 0, 0, 6);
    runVector("B.c7",  0, 1, 0, 0, 1, 1, 0, 1, 5);
    runVector("B.c8",  0, 1, 0, 0, 1, 0, 0, 1, 5);
    runVector("B.c9",  0, 1, 0, 0, 1, 0, 0, 1, 5);
    runVector("B.c10", 0, 1, 0, 0, 0, 0, 0, 1, 5);
    runVector("B.c11", 0, 1, 0, 0, 0, 0, 0, 1, 5);
    runVector("B.c12", 0, 1, 0, 0, 1, 1, 0, 1, 5);

    // Zero divisor rejected with a single error pulse
    runVector("C.rst", 1, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("C.c1",  0, 1, 1, 0, 1, 1, 1, 1, 6);
    runVector("C.c2",  0, 1, 0, 0, 1, 0, 0, 1, 6);
    runVector("C.c3",  0, 1, 0, 0, 1, 0, 0, 1, 6);
    runVector("C.c4",  0, 1, 0, 0, 0, 0, 0, 1, 6);
    runVector("C.c5",  0, 1, 0, 0, 0, 0, 0, 1, 6);
    runVector("C.c6",  0, 1, 0, 0, 0, 0, 0, 1, 6);
    runVector("C.c7",  0, 1, 0, 0, 1, 1, 0, 1, 6);

    // Enable low for four cycles mid-period
    runVector("D.rst", 1, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("D.c1",  0, 1, 0, 0, 1, 1, 0, 1, 6);
    runVector("D.c2",  0, 1, 0, 0, 1, 0, 0, 1, 6);
    runVector("D.c3",  0, 1, 0, 0, 1, 0, 0, 1, 6);
    runVector("D.c4",  0, 1, 0, 0, 0, 0, 0, 1, 6);
    for (int i = 0; i < 4; i++)
      runVector($sformatf("D.f%0d", i + 1), 0, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("D.c9",  0, 1, 0, 0, 0, 0, 0, 1, 6);
    runVector("D.c10", 0, 1, 0, 0, 0, 0, 0, 1, 6);
    runVector("D.c11", 0, 1, 0, 0, 1, 1, 0, 1, 6);
    runVector("D.c12", 0, 1, 0, 0, 1, 0, 0, 1, 6);

    // D=1 then D=2, each request accepted on a wrap cycle
    runVector("E.rst", 1, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("E.c1",  0, 1, 1, 1, 1, 1, 0, 0, 6);
    runVector("E.c2",  0, 1, 0, 0, 1, 0, 0, 0, 6);
    runVector("E.c3",  0, 1, 0, 0, 1, 0, 0, 0, 6);
    runVector("E.c4",  0, 1, 0, 0, 0, 0, 0, 0, 6);
    runVector("E.c5",  0, 1, 0, 0, 0, 0, 0, 0, 6);
    runVector("E.c6",  0, 1, 0, 0, 0, 0, 0, 0, 6);
    runVector("E.c7",  0, 1, 0, 0, 1, 1, 0, 1, 1);
    runVector("E.c8",  0, 1, 1, 2, 1, 1, 0, 0, 1);
    runVector("E.c9",  0, 1, 0, 0, 1, 1, 0, 1, 2);
    runVector("E.c10", 0, 1, 0, 0, 0, 0, 0, 1, 2);
    runVector("E.c11", 0, 1, 0, 0, 1, 1, 0, 1, 2);
    runVector("E.c12", 0, 1, 0, 0, 0, 0, 0, 1, 2);

    // Application while disabled, then reset discarding a pending request
    runVector("F.rst", 1, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("F.c1",  0, 1, 0, 0, 1, 1, 0, 1, 6);
    runVector("F.c2",  0, 1, 1, 4, 1, 0, 0, 0, 6);
    runVector("F.c3",  0, 0, 0, 0, 1, 0, 0, 1, 4);
    runVector("F.c4",  0, 1, 0, 0, 1, 1, 0, 1, 4);
    runVector("F.c5",  0, 1, 0, 0, 1, 0, 0, 1, 4);
    runVector("F.c6",  0, 1, 0, 0, 0, 0, 0, 1, 4);
    runVector("F.c7",  0, 1, 0, 0, 0, 0, 0, 1, 4);
    runVector("F.c8",  0, 1, 0, 0, 1, 1, 0, 1, 4);
    runVector("F.c9",  0, 1, 1, 3, 1, 0, 0, 0, 4);
    runVector("F.c10", 1, 1, 1, 7, 0, 0, 0, 1, 6);
    runVector("F.c11", 0, 0, 0, 0, 0, 0, 0, 1, 6);
    runVector("F.c12", 0, 1, 0, 0, 1, 1, 0, 1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8: divisor and counter width in bits; legal range 2..16.
REQ-002 Parameter RESET_DIV, default 6: divisor loaded at reset; legal range 1..2^WIDTH-1.
REQ-003 Port i_clk  input  1: single clock for all state.
REQ-004 Port i_rst  input  1: reset, synchronous, active-high.
REQ-005 Port i_en  input  1: count enable; low freezes the divider.
REQ-006 Port i_div  input  WIDTH: requested divisor D.
REQ-007 Port i_div_valid  input  1: i_div is valid this cycle.
REQ-008 Port o_div_ready  output  1: block can accept a divisor request.
REQ-009 Port o_div_err  output  1: one-cycle pulse when a zero divisor is rejected.
REQ-010 Port o_clk  output  1: divided clock, registered.
REQ-011 Port o_tick  output  1: one-cycle pulse at the start of each output period.
REQ-012 Port o_div_active  output  WIDTH: divisor currently in force.

Function
REQ-013 State: ctr (WIDTH bits), active divisor D, pending divisor P with pending flag; H = ceil(D/2), computed in WIDTH+1 bits.
REQ-014 Enabled cycle with ctr == D-1 (wrap): ctr<=0, o_clk<=1, o_tick<=1.
REQ-015 Enabled cycle with ctr != D-1: ctr<=ctr+1, o_clk<=(ctr+1 < H), o_tick<=0.
REQ-016 Result: o_clk is high for ceil(D/2) and low for floor(D/2) enabled cycles per period of D enabled cycles.
REQ-017 D == 1: wrap every enabled cycle; o_clk stays 1; o_tick is high on every enabled cycle.
REQ-018 i_en low: ctr and o_clk hold; o_tick<=0.
REQ-019 o_div_ready = not pending.
REQ-020 Handshake: an accept occurs when i_div_valid && o_div_ready; if i_div != 0, P<=i_div and pending is set.
REQ-021 On an accept with i_div == 0: request dropped, pending stays clear, o_div_err<=1 for exactly one cycle.
REQ-022 Pending applies on the next enabled wrap cycle: D<=P, ctr<=0, o_clk<=1, o_tick<=1, pending cleared; the following period uses the new D.
REQ-023 Pending applies on any cycle with i_en low: D<=P, ctr<=P-1, pending cleared; the next enabled cycle is a wrap.
REQ-024 Accept on the same cycle as a wrap: value goes to P only; it is applied at the following wrap, never the current one.
REQ-025 o_div_ready returns high the cycle after application; a new accept is possible on that cycle.
REQ-026 o_div_active = D, registered; it changes on the same edge that applies the new divisor.
REQ-027 i_div_valid while o_div_ready is low: ignored, with no error pulse.

Reset
REQ-028 i_rst dominates all other inputs, including a mid-period reset or one coinciding with an accept.
REQ-029 Reset values: D=RESET_DIV, ctr=RESET_DIV-1, pending=0, o_clk=0, o_tick=0, o_div_err=0, o_div_ready=1, o_div_active=RESET_DIV.
REQ-030 The first enabled cycle after reset is a wrap, so output periods are phase-aligned to i_en rising.

Verification
REQ-031 Reset, RESET_DIV=6, i_en=1 for 12 cycles -> o_clk 1,1,1,0,0,0,1,1,1,0,0,0; o_tick on cycles 1 and 7.
REQ-032 Request i_div=5 at cycle 2 of a D=6 period -> o_div_ready low until the wrap at cycle 7; then o_clk 1,1,1,0,0 repeats; o_div_active=5 from cycle 7.
REQ-033 i_div=0 with valid -> o_div_err pulses one cycle; D unchanged; o_div_ready stays high.
REQ-034 i_en low for 4 cycles mid-period with D=6 -> o_clk and ctr frozen; the period resumes with the remaining cycles; no o_tick while frozen.
REQ-035 D=1 then D=2 -> o_clk constant 1 with o_tick every cycle, then o_clk 1,0 alternating after the next wrap.
REQ-036 i_rst asserted mid-period with a pending request -> pending discarded; outputs match the REQ-029 reset values on the next cycle.
